nvp_command_scheduler: RTL and testbench

- Sequences layer commands for the NVP accelerator datapath.
- Buffers layer commands written from the control register bank in a small FIFO.
- For each command, configures the datapath with row and channel counts, then issues output rows one at a time.
- Each row waits for the datapath's line-stored acknowledge. The block drives o_output_line_stored per row and o_next_command_interrupt per finished command.

---
 rtl/nvp_command_scheduler_if.sv | 43 ++++
 rtl/nvp_command_scheduler.sv | 155 +++++++++++++++
 tb/tb_nvp_command_scheduler.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nvp_command_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : nvp_command_scheduler_if
// Description : Command-push and datapath handshake bundle of the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface nvp_command_scheduler_if #(
  parameter int ROWS_BIT_WIDTH     = 10,
  parameter int CHANNELS_BIT_WIDTH = 10,
  parameter int CMD_FIFO_DEPTH     = 4
);
  localparam int c_COUNT_WIDTH = $clog2(CMD_FIFO_DEPTH) + 1;

  logic [ROWS_BIT_WIDTH+CHANNELS_BIT_WIDTH-1:0] i_cmd_data;
  logic                                         i_cmd_valid;
  logic                                         o_cmd_ready;
  logic [c_COUNT_WIDTH-1:0]                     o_fifo_count;
  logic                                         o_layer_start;
  logic [ROWS_BIT_WIDTH-1:0]                    o_layer_rows;
  logic [CHANNELS_BIT_WIDTH-1:0]                o_layer_channels;
  logic                                         o_row_start;
  logic [ROWS_BIT_WIDTH-1:0]                    o_row_index;
  logic                                         i_row_done;
  logic                                         o_output_line_stored;
  logic                                         o_next_command_interrupt;
  logic                                         o_busy;

  // Master is the control/datapath side, slave is the scheduler.
  modport master (
    output i_cmd_data, i_cmd_valid, i_row_done,
    input  o_cmd_ready, o_fifo_count, o_layer_start, o_layer_rows,
           o_layer_channels, o_row_start, o_row_index,
           o_output_line_stored, o_next_command_interrupt, o_busy
  );

  modport slave (
    input  i_cmd_data, i_cmd_valid, i_row_done,
    output o_cmd_ready, o_fifo_count, o_layer_start, o_layer_rows,
           o_layer_channels, o_row_start, o_row_index,
           o_output_line_stored, o_next_command_interrupt, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/nvp_command_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : nvp_command_scheduler
// Description : Queues layer commands and issues datapath rows one at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module nvp_command_scheduler #(
  parameter int ROWS_BIT_WIDTH     = 10,
  parameter int CHANNELS_BIT_WIDTH = 10,
  parameter int CMD_FIFO_DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  nvp_command_scheduler_if.slave bus
);
  localparam int c_PTR_WIDTH   = $clog2(CMD_FIFO_DEPTH);
  localparam int c_COUNT_WIDTH = c_PTR_WIDTH + 1;
  localparam int c_CMD_WIDTH   = ROWS_BIT_WIDTH + CHANNELS_BIT_WIDTH;

  localparam logic [c_COUNT_WIDTH-1:0]  c_FULL_COUNT = c_COUNT_WIDTH'(CMD_FIFO_DEPTH);
  localparam logic [c_COUNT_WIDTH-1:0]  c_COUNT_ONE  = c_COUNT_WIDTH'(1);
  localparam logic [c_PTR_WIDTH-1:0]    c_PTR_ONE    = c_PTR_WIDTH'(1);
  localparam logic [ROWS_BIT_WIDTH-1:0] c_ROW_ONE    = ROWS_BIT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_ISSUE_ROW = 3'd2,
    S_WAIT_ROW  = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t                        r_state;
  state_t                        w_state_next;
  logic [c_CMD_WIDTH-1:0]        r_fifo_mem [CMD_FIFO_DEPTH];
  logic [c_PTR_WIDTH-1:0]        r_wr_ptr;
  logic [c_PTR_WIDTH-1:0]        r_rd_ptr;
  logic [c_COUNT_WIDTH-1:0]      r_count;
  logic [ROWS_BIT_WIDTH-1:0]     r_layer_rows;
  logic [CHANNELS_BIT_WIDTH-1:0] r_layer_channels;
  logic [ROWS_BIT_WIDTH-1:0]     r_row_cnt;
  logic                          r_line_stored;

  logic                          w_full;
  logic                          w_push;
  logic                          w_pop;
  logic                          w_row_accept;
  logic                          w_last_row;
  logic [c_CMD_WIDTH-1:0]        w_head;
  logic                          w_layer_start;
  logic                          w_row_start;
  logic                          w_interrupt;
  logic                          w_busy;

  assign w_full       = (r_count == c_FULL_COUNT);
  assign w_push       = bus.i_cmd_valid && !w_full;
  assign w_pop        = (r_state == S_IDLE) && (r_count != '0);
  assign w_row_accept = (r_state == S_WAIT_ROW) && bus.i_row_done;
  assign w_last_row   = (r_row_cnt == (r_layer_rows - c_ROW_ONE));
  assign w_head       = r_fifo_mem[r_rd_ptr];

  // Storage needs no reset: entries are only read once counted as valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= bus.i_cmd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_COUNT_ONE;
        2'b01:   r_count <= r_count - c_COUNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_layer_start = 1'b0;
    w_row_start   = 1'b0;
    w_interrupt   = 1'b0;
    w_busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (r_count != '0) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        w_layer_start = 1'b1;
        w_state_next  = (r_layer_rows == '0) ? S_DONE : S_ISSUE_ROW;
      end
      S_ISSUE_ROW: begin
        w_row_start  = 1'b1;
        w_state_next = S_WAIT_ROW;
      end
      S_WAIT_ROW: begin
        if (bus.i_row_done) w_state_next = w_last_row ? S_DONE : S_ISSUE_ROW;
      end
      S_DONE: begin
        w_interrupt  = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_busy       = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_layer_rows     <= '0;
      r_layer_channels <= '0;
      r_row_cnt        <= '0;
      r_line_stored    <= 1'b0;
    end else begin
      r_line_stored <= w_row_accept;
      if (w_pop) begin
        r_layer_rows     <= w_head[ROWS_BIT_WIDTH-1:0];
        r_layer_channels <= w_head[c_CMD_WIDTH-1:ROWS_BIT_WIDTH];
        r_row_cnt        <= '0;
      end else if (w_row_accept && !w_last_row) begin
        r_row_cnt <= r_row_cnt + c_ROW_ONE;
      end
    end
  end

  assign bus.o_cmd_ready              = !w_full;
  assign bus.o_fifo_count             = r_count;
  assign bus.o_layer_start            = w_layer_start;
  assign bus.o_layer_rows             = r_layer_rows;
  assign bus.o_layer_channels         = r_layer_channels;
  assign bus.o_row_start              = w_row_start;
  assign bus.o_row_index              = r_row_cnt;
  assign bus.o_output_line_stored     = r_line_stored;
  assign bus.o_next_command_interrupt = w_interrupt;
  assign bus.o_busy                   = w_busy;
endmodule
`default_nettype wire

// File: tb/tb_nvp_command_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_nvp_command_scheduler
// Description : Directed self-checking bench for nvp_command_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nvp_command_scheduler;
  localparam int ROWS_W = 10;
  localparam int CH_W   = 10;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic resetn;

  nvp_command_scheduler_if #(
    .ROWS_BIT_WIDTH(ROWS_W), .CHANNELS_BIT_WIDTH(CH_W), .CMD_FIFO_DEPTH(DEPTH)
  ) bus ();

  nvp_command_scheduler #(
    .ROWS_BIT_WIDTH(ROWS_W), .CHANNELS_BIT_WIDTH(CH_W), .CMD_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-cycle pulse history and logged values captured by monitor().
  logic [63:0] m_ls, m_rs, m_lsd, m_int, m_busy;
  int q_idx[$];
  int q_ch[$];
  int q_rows[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input int ch, input int rows);
    bus.i_cmd_data  = {CH_W'(ch), ROWS_W'(rows)};
    bus.i_cmd_valid = 1'b1;
    tick();
    bus.i_cmd_valid = 1'b0;
  endtask

  task automatic monitor(input int n);
    m_ls = '0; m_rs = '0; m_lsd = '0; m_int = '0; m_busy = '0;
    q_idx.delete(); q_ch.delete(); q_rows.delete();
    for (int c = 0; c < n; c++) begin
      m_ls[c]   = bus.o_layer_start;
      m_rs[c]   = bus.o_row_start;
      m_lsd[c]  = bus.o_output_line_stored;
      m_int[c]  = bus.o_next_command_interrupt;
      m_busy[c] = bus.o_busy;
      if (bus.o_row_start) q_idx.push_back(int'(bus.o_row_index));
      if (bus.o_layer_start) begin
        q_ch.push_back(int'(bus.o_layer_channels));
        q_rows.push_back(int'(bus.o_layer_rows));
      end
      tick();
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.i_cmd_valid = 1'b0; bus.i_row_done = 1'b0; bus.i_cmd_data = '0;
    tick(); tick();
    checks++;
    if ({bus.o_layer_start, bus.o_row_start, bus.o_output_line_stored,
         bus.o_next_command_interrupt, bus.o_busy} !== 5'b0) begin
      errors++; $display("FAIL reset_pulses got %b expected 00000", {bus.o_layer_start,
        bus.o_row_start, bus.o_output_line_stored, bus.o_next_command_interrupt, bus.o_busy});
    end
    checks++;
    if ({bus.o_layer_rows, bus.o_layer_channels, bus.o_row_index} !== '0) begin
      errors++; $display("FAIL reset_fields got rows=%0d ch=%0d idx=%0d expected 0",
        bus.o_layer_rows, bus.o_layer_channels, bus.o_row_index);
    end
    checks++;
    if (bus.o_cmd_ready !== 1'b1 || bus.o_fifo_count !== 3'd0) begin
      errors++; $display("FAIL reset_fifo got ready=%b count=%0d expected ready=1 count=0",
        bus.o_cmd_ready, bus.o_fifo_count);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single_command();
    bus.i_row_done = 1'b1;
    push_cmd(16, 3);
    monitor(12);
    checks++;
    if (m_ls !== 64'h2) begin errors++; $display("FAIL single_layer_start got %h expected 2", m_ls); end
    checks++;
    if (q_rows.size() != 1 || q_rows[0] != 3 || q_ch[0] != 16) begin
      errors++; $display("FAIL single_config got n=%0d rows=%0d ch=%0d expected n=1 rows=3 ch=16",
        q_rows.size(), (q_rows.size() > 0) ? q_rows[0] : -1, (q_ch.size() > 0) ? q_ch[0] : -1);
    end
    checks++;
    if (m_rs !== 64'h54) begin errors++; $display("FAIL single_row_start got %h expected 54", m_rs); end
    checks++;
    if (q_idx.size() != 3 || q_idx[0] != 0 || q_idx[1] != 1 || q_idx[2] != 2) begin
      errors++; $display("FAIL single_row_index got n=%0d expected indices 0,1,2", q_idx.size());
    end
    checks++;
    if (m_lsd !== 64'h150) begin errors++; $display("FAIL single_line_stored got %h expected 150", m_lsd); end
    checks++;
    if (m_int !== 64'h100) begin errors++; $display("FAIL single_interrupt got %h expected 100", m_int); end
    checks++;
    if (m_busy !== 64'h1fe) begin errors++; $display("FAIL single_busy got %h expected 1fe", m_busy); end
  endtask

  task automatic test_fifo_full();
    int exp_ch[4] = '{11, 12, 13, 14};
    bus.i_row_done = 1'b0;
    push_cmd(10, 1);
    push_cmd(11, 1);
    checks++;
    if (bus.o_layer_start !== 1'b1 || bus.o_layer_channels !== 10'd10 || bus.o_fifo_count !== 3'd1) begin
      errors++; $display("FAIL full_first_pop got start=%b ch=%0d count=%0d expected 1,10,1",
        bus.o_layer_start, bus.o_layer_channels, bus.o_fifo_count);
    end
    push_cmd(12, 1); push_cmd(13, 1); push_cmd(14, 1);
    checks++;
    if (bus.o_fifo_count !== 3'd4 || bus.o_cmd_ready !== 1'b0) begin
      errors++; $display("FAIL full_count got count=%0d ready=%b expected 4,0",
        bus.o_fifo_count, bus.o_cmd_ready);
    end
    push_cmd(15, 1);
    checks++;
    if (bus.o_fifo_count !== 3'd4 || bus.o_layer_channels !== 10'd10) begin
      errors++; $display("FAIL full_drop got count=%0d ch=%0d expected 4,10",
        bus.o_fifo_count, bus.o_layer_channels);
    end
    bus.i_row_done = 1'b1;
    monitor(40);
    checks++;
    if ($countones(m_int) != 5 || $countones(m_lsd) != 5) begin
      errors++; $display("FAIL full_run got int=%0d lines=%0d expected 5,5",
        $countones(m_int), $countones(m_lsd));
    end
    checks++;
    if (q_ch.size() != 4 || q_ch[0] != exp_ch[0] || q_ch[1] != exp_ch[1] ||
        q_ch[2] != exp_ch[2] || q_ch[3] != exp_ch[3]) begin
      errors++; $display("FAIL full_order got %0d layer starts expected channels 11,12,13,14", q_ch.size());
    end
    checks++;
    if (bus.o_fifo_count !== 3'd0 || bus.o_busy !== 1'b0) begin
      errors++; $display("FAIL full_drain got count=%0d busy=%b expected 0,0",
        bus.o_fifo_count, bus.o_busy);
    end
  endtask

  task automatic test_zero_rows();
    bus.i_row_done = 1'b1;
    push_cmd(5, 0);
    monitor(6);
    checks++;
    if (m_ls !== 64'h2 || m_int !== 64'h4 || m_busy !== 64'h6) begin
      errors++; $display("FAIL zero_seq got ls=%h int=%h busy=%h expected 2,4,6", m_ls, m_int, m_busy);
    end
    checks++;
    if (m_rs !== 64'h0 || m_lsd !== 64'h0) begin
      errors++; $display("FAIL zero_no_rows got rs=%h lsd=%h expected 0,0", m_rs, m_lsd);
    end
    checks++;
    if (q_ch.size() != 1 || q_ch[0] != 5 || q_rows[0] != 0) begin
      errors++; $display("FAIL zero_config got n=%0d expected ch=5 rows=0", q_ch.size());
    end
  endtask

  task automatic test_spurious_done();
    bus.i_row_done = 1'b1;
    tick();
    bus.i_row_done = 1'b0;
    checks++;
    if (bus.o_output_line_stored !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_row_index !== 10'd0) begin
      errors++; $display("FAIL spurious_idle got lsd=%b busy=%b idx=%0d expected 0,0,0",
        bus.o_output_line_stored, bus.o_busy, bus.o_row_index);
    end
    push_cmd(7, 2);
    tick();
    tick();
    checks++;
    if (bus.o_row_start !== 1'b1 || bus.o_row_index !== 10'd0) begin
      errors++; $display("FAIL spurious_issue got rs=%b idx=%0d expected 1,0",
        bus.o_row_start, bus.o_row_index);
    end
    bus.i_row_done = 1'b1;
    tick();
    bus.i_row_done = 1'b0;
    tick(); tick();
    checks++;
    if (bus.o_output_line_stored !== 1'b0 || bus.o_row_start !== 1'b0 ||
        bus.o_busy !== 1'b1 || bus.o_row_index !== 10'd0 || bus.o_next_command_interrupt !== 1'b0) begin
      errors++; $display("FAIL spurious_wait got lsd=%b rs=%b busy=%b idx=%0d expected 0,0,1,0",
        bus.o_output_line_stored, bus.o_row_start, bus.o_busy, bus.o_row_index);
    end
    bus.i_row_done = 1'b1;
    monitor(8);
    checks++;
    if (m_lsd !== 64'ha || m_rs !== 64'h2 || m_int !== 64'h8) begin
      errors++; $display("FAIL spurious_resume got lsd=%h rs=%h int=%h expected a,2,8", m_lsd, m_rs, m_int);
    end
  endtask

  task automatic test_reset_mid_command();
    bus.i_row_done = 1'b0;
    push_cmd(1, 4); push_cmd(2, 1); push_cmd(3, 1);
    tick();
    bus.i_row_done = 1'b1;
    tick();
    bus.i_row_done = 1'b0;
    tick();
    checks++;
    if (bus.o_row_index !== 10'd1 || bus.o_fifo_count !== 3'd2 || bus.o_busy !== 1'b1) begin
      errors++; $display("FAIL midrst_setup got idx=%0d count=%0d busy=%b expected 1,2,1",
        bus.o_row_index, bus.o_fifo_count, bus.o_busy);
    end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    checks++;
    if ({bus.o_layer_start, bus.o_row_start, bus.o_output_line_stored,
         bus.o_next_command_interrupt, bus.o_busy} !== 5'b0 ||
        {bus.o_layer_rows, bus.o_layer_channels, bus.o_row_index} !== '0) begin
      errors++; $display("FAIL midrst_outputs got rows=%0d ch=%0d idx=%0d busy=%b expected all 0",
        bus.o_layer_rows, bus.o_layer_channels, bus.o_row_index, bus.o_busy);
    end
    checks++;
    if (bus.o_cmd_ready !== 1'b1 || bus.o_fifo_count !== 3'd0) begin
      errors++; $display("FAIL midrst_fifo got ready=%b count=%0d expected 1,0",
        bus.o_cmd_ready, bus.o_fifo_count);
    end
    bus.i_row_done = 1'b1;
    monitor(20);
    checks++;
    if (m_int !== 64'h0 || m_ls !== 64'h0 || m_busy !== 64'h0) begin
      errors++; $display("FAIL midrst_quiet got int=%h ls=%h busy=%h expected 0,0,0", m_int, m_ls, m_busy);
    end
    bus.i_row_done = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.i_row_done = 1'b1;
    push_cmd(21, 1);
    push_cmd(22, 1);
    monitor(12);
    checks++;
    if (m_ls !== 64'h21 || m_int !== 64'h108) begin
      errors++; $display("FAIL b2b_timing got ls=%h int=%h expected 21,108", m_ls, m_int);
    end
    checks++;
    if (m_busy !== 64'h1ef) begin errors++; $display("FAIL b2b_idle_gap got busy=%h expected 1ef", m_busy); end
    checks++;
    if (q_ch.size() != 2 || q_ch[0] != 21 || q_ch[1] != 22) begin
      errors++; $display("FAIL b2b_order got n=%0d expected channels 21,22", q_ch.size());
    end
    bus.i_row_done = 1'b0;
  endtask

  initial begin
    bus.i_cmd_valid = 1'b0;
    bus.i_row_done  = 1'b0;
    bus.i_cmd_data  = '0;
    resetn          = 1'b0;
    test_reset();
    test_single_command();
    test_fifo_full();
    test_zero_rows();
    test_spurious_done();
    test_reset_mid_command();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
